// File: rtl/timer_sched.sv
// timer_sched: four-channel microsecond timer scheduler behind a CE-decoded slave port.
// Register map (by CE index k, CE bit C_NUM_REG-1-k): 0 CTRL, 1 PEND, 2-5 PERIOD0-3,
// 6 CHCTRL, 7 COUNT. One shared decrement/compare datapath is time-multiplexed over the
// channels by a 4-cycle scan (IDLE -> SCAN0..SCAN3 -> IDLE).
// Optional feature: define TIMER_SCHED_OVERRUN_EN to latch dropped ticks in CTRL bit8.
// Bus handshake: RdAck/WrAck are the OR of the respective CE bits in the same cycle;
// there is no wait state and Error is always 0.
module timer_sched #(
  parameter int C_NUM_REG    = 8,
  parameter int C_SLV_DWIDTH = 32
) (
  input  logic                      Bus2IP_Clk,
  input  logic                      Bus2IP_Resetn,
  input  logic                      Tick_Us,
  input  logic [C_SLV_DWIDTH-1:0]   Bus2IP_Data,
  input  logic [C_SLV_DWIDTH/8-1:0] Bus2IP_BE,
  input  logic [C_NUM_REG-1:0]      Bus2IP_RdCE,
  input  logic [C_NUM_REG-1:0]      Bus2IP_WrCE,
  output logic [C_SLV_DWIDTH-1:0]   IP2Bus_Data,
  output logic                      IP2Bus_RdAck,
  output logic                      IP2Bus_WrAck,
  output logic                      IP2Bus_Error,
  output logic                      Sched_Int,
  output logic [2:0]                o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN0 = 3'd1,
    S_SCAN1 = 3'd2,
    S_SCAN2 = 3'd3,
    S_SCAN3 = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_tick_pend, w_tick_pend_nxt;
  logic        r_en, r_ie;
  logic [1:0]  r_sel;
  logic [3:0]  r_pend, r_ch_en, r_ch_per, r_ch_mask;
  logic [31:0] r_period [4];
  logic [31:0] r_count  [4];
  logic        r_int;
  logic        w_overrun;

  logic [7:0]  w_wr_sel, w_rd_sel;
  logic [31:0] w_per_wr [4];
  logic [3:0]  w_pend_clr, w_en_new, w_en_rise, w_set;
  logic [1:0]  w_scan_ch;
  logic        w_scan_act, w_go, w_blk, w_fire, w_dec, w_upd, w_oneshot_clr;
  logic [31:0] w_cur_cnt, w_cur_period, w_scan_cnt;

  // Merge new write data into an old value under the byte enables.
  function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
    f_merge = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) f_merge[b*8 +: 8] = new_v[b*8 +: 8];
    end
  endfunction

  // Chip-enable decode: register k sits on CE bit C_NUM_REG-1-k.
  always_comb begin
    w_wr_sel = '0;
    w_rd_sel = '0;
    for (int k = 0; k < 8; k++) begin
      w_wr_sel[k] = Bus2IP_WrCE[C_NUM_REG-1-k];
      w_rd_sel[k] = Bus2IP_RdCE[C_NUM_REG-1-k];
    end
  end

  // Write-side helpers: merged period data, PEND clear mask, channel-enable rising edges.
  always_comb begin
    for (int i = 0; i < 4; i++) w_per_wr[i] = f_merge(r_period[i], Bus2IP_Data, Bus2IP_BE);
    w_pend_clr = (w_wr_sel[1] && Bus2IP_BE[0]) ? Bus2IP_Data[3:0] : 4'd0;
    w_en_new   = (w_wr_sel[6] && Bus2IP_BE[0]) ? Bus2IP_Data[3:0] : r_ch_en;
    w_en_rise  = w_en_new & ~r_ch_en;
  end

  // Shared scan datapath: the channel under scan is decremented, fired or held; a bus
  // write to that channel's PERIOD or to CHCTRL in the same cycle suppresses the update.
  always_comb begin
    w_scan_act = (r_state != S_IDLE);
    case (r_state)
      S_SCAN1: w_scan_ch = 2'd1;
      S_SCAN2: w_scan_ch = 2'd2;
      S_SCAN3: w_scan_ch = 2'd3;
      default: w_scan_ch = 2'd0;
    endcase
    w_cur_cnt     = r_count[w_scan_ch];
    w_cur_period  = r_period[w_scan_ch];
    w_blk         = w_wr_sel[6] | w_wr_sel[2 + 32'(w_scan_ch)];
    w_fire        = w_scan_act & r_ch_en[w_scan_ch] & (w_cur_cnt == 32'd1) & ~w_blk;
    w_dec         = w_scan_act & r_ch_en[w_scan_ch] & (w_cur_cnt > 32'd1) & ~w_blk;
    w_upd         = w_fire | w_dec;
    w_oneshot_clr = w_fire & ~r_ch_per[w_scan_ch];
    w_set         = w_fire ? (4'b0001 << w_scan_ch) : 4'd0;
    if (w_fire) w_scan_cnt = r_ch_per[w_scan_ch] ? w_cur_period : 32'd0;
    else        w_scan_cnt = w_cur_cnt - 32'd1;
  end

  // Scan FSM next state and tick latch: a tick during a scan is held once, a second is dropped.
  always_comb begin
    w_state_nxt     = r_state;
    w_tick_pend_nxt = r_tick_pend;
    w_go            = r_en & (Tick_Us | r_tick_pend);
    case (r_state)
      S_IDLE: begin
        if (w_go) w_state_nxt = S_SCAN0;
        if (w_go || !r_en) w_tick_pend_nxt = 1'b0;
      end
      S_SCAN0: w_state_nxt = S_SCAN1;
      S_SCAN1: w_state_nxt = S_SCAN2;
      S_SCAN2: w_state_nxt = S_SCAN3;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_scan_act) begin
      if (!r_en)        w_tick_pend_nxt = 1'b0;
      else if (Tick_Us) w_tick_pend_nxt = 1'b1;
    end
  end

  // FSM state and tick-pending register.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      r_state     <= S_IDLE;
      r_tick_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick_pend <= w_tick_pend_nxt;
    end
  end

  // CTRL register fields (enable, interrupt enable, COUNT channel select).
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      r_en  <= 1'b0;
      r_ie  <= 1'b0;
      r_sel <= 2'd0;
    end else if (w_wr_sel[0] && Bus2IP_BE[0]) begin
      r_en  <= Bus2IP_Data[0];
      r_ie  <= Bus2IP_Data[1];
      r_sel <= Bus2IP_Data[5:4];
    end
  end

`ifdef TIMER_SCHED_OVERRUN_EN
  logic r_overrun;
  logic w_drop, w_ovr_clr;
  assign w_drop    = w_scan_act & r_en & Tick_Us & r_tick_pend;
  assign w_ovr_clr = w_wr_sel[0] & Bus2IP_BE[1] & Bus2IP_Data[8];
  // Sticky overrun flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn)  r_overrun <= 1'b0;
    else if (w_drop)     r_overrun <= 1'b1;
    else if (w_ovr_clr)  r_overrun <= 1'b0;
  end
  assign w_overrun = r_overrun;
`else
  assign w_overrun = 1'b0;
`endif

  // Channel state: PEND, CHCTRL fields, periods and counts (bus writes beat scan updates).
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      r_pend    <= 4'd0;
      r_ch_en   <= 4'd0;
      r_ch_per  <= 4'd0;
      r_ch_mask <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        r_period[i] <= 32'd0;
        r_count[i]  <= 32'd0;
      end
    end else begin
      r_pend <= (r_pend & ~w_pend_clr) | w_set;
      if (w_wr_sel[6] && Bus2IP_BE[0]) begin
        r_ch_en  <= Bus2IP_Data[3:0];
        r_ch_per <= Bus2IP_Data[7:4];
      end else if (w_oneshot_clr) begin
        r_ch_en[w_scan_ch] <= 1'b0;
      end
      if (w_wr_sel[6] && Bus2IP_BE[1]) r_ch_mask <= Bus2IP_Data[11:8];
      for (int i = 0; i < 4; i++) begin
        if (w_wr_sel[2+i]) begin
          r_period[i] <= w_per_wr[i];
          r_count[i]  <= w_per_wr[i];
        end else if (w_wr_sel[6] && w_en_rise[i]) begin
          r_count[i] <= r_period[i];
        end else if (w_upd && (w_scan_ch == 2'(i))) begin
          r_count[i] <= w_scan_cnt;
        end
      end
    end
  end

  // Registered level interrupt.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) r_int <= 1'b0;
    else                r_int <= r_ie & |(r_pend & r_ch_mask);
  end

  // Read mux; zero when no read CE is active.
  always_comb begin
    IP2Bus_Data = '0;
    if (w_rd_sel[0]) IP2Bus_Data = {23'd0, w_overrun, 2'd0, r_sel, 2'd0, r_ie, r_en};
    if (w_rd_sel[1]) IP2Bus_Data = {28'd0, r_pend};
    for (int i = 0; i < 4; i++) begin
      if (w_rd_sel[2+i]) IP2Bus_Data = r_period[i];
    end
    if (w_rd_sel[6]) IP2Bus_Data = {20'd0, r_ch_mask, r_ch_per, r_ch_en};
    if (w_rd_sel[7]) IP2Bus_Data = r_count[r_sel];
  end

  assign IP2Bus_RdAck = |Bus2IP_RdCE;
  assign IP2Bus_WrAck = |Bus2IP_WrCE;
  assign IP2Bus_Error = 1'b0;
  assign Sched_Int    = r_int;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched; define TIMER_SCHED_OVERRUN_EN for both files to test overrun.
module tb_timer_sched;

  localparam int R_CTRL = 0, R_PEND = 1, R_PER0 = 2, R_CHCTRL = 6, R_COUNT = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic [7:0]  rd_ce = '0, wr_ce = '0;
  logic [31:0] rdata;
  logic        rd_ack, wr_ack, err, sint;
  logic [2:0]  dbg;
  int          n_checks = 0, n_fail = 0;
  logic [31:0] exp_ovr;

  // clock / reset block
  always #5 clk = ~clk;

  timer_sched #(.C_NUM_REG(8), .C_SLV_DWIDTH(32)) dut (
    .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n), .Tick_Us(tick),
    .Bus2IP_Data(wdata), .Bus2IP_BE(be), .Bus2IP_RdCE(rd_ce), .Bus2IP_WrCE(wr_ce),
    .IP2Bus_Data(rdata), .IP2Bus_RdAck(rd_ack), .IP2Bus_WrAck(wr_ack),
    .IP2Bus_Error(err), .Sched_Int(sint), .o_dbg_state(dbg)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; tick = 1'b0; wr_ce = '0; rd_ce = '0; be = '0; wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input int k, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    wr_ce = 8'h80 >> k; wdata = d; be = b;
    @(negedge clk);
    wr_ce = '0; wdata = '0; be = '0;
  endtask

  task automatic rd_chk(input int k, input logic [31:0] exp, input string tag);
    @(negedge clk);
    rd_ce = 8'h80 >> k;
    #1;
    chk(tag, rdata, exp);
    chk({tag, "_ack"}, {31'd0, rd_ack}, 32'd1);
    rd_ce = '0;
  endtask

  task automatic pulse_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef TIMER_SCHED_OVERRUN_EN
    exp_ovr = 32'h100;
`else
    exp_ovr = 32'h0;
`endif
    // ---- reset state
    do_reset();
    #1;
    chk("rst_int", {31'd0, sint}, 32'd0);
    chk("rst_state", {29'd0, dbg}, 32'd0);
    chk("idle_data", rdata, 32'd0);
    chk("idle_ack", {30'd0, rd_ack, wr_ack}, 32'd0);
    chk("err", {31'd0, err}, 32'd0);
    for (int k = 0; k < 8; k++) rd_chk(k, 32'd0, $sformatf("rst_reg%0d", k));

    // ---- byte enables: PERIOD3 merge, COUNT follows the write
    bus_write(R_PER0 + 3, 32'hAABBCCDD, 4'hF);
    bus_write(R_PER0 + 3, 32'h11223344, 4'h5);
    rd_chk(R_PER0 + 3, 32'hAA22CC44, "be_period3");
    bus_write(R_CTRL, 32'h30, 4'hF);
    rd_chk(R_CTRL, 32'h30, "ctrl_sel3");
    rd_chk(R_COUNT, 32'hAA22CC44, "count3_loaded");

    // ---- ch0 periodic, period 3: fires on ticks 3, 6, 9
    do_reset();
    bus_write(R_PER0, 32'd3, 4'hF);
    bus_write(R_CHCTRL, 32'h111, 4'hF);
    bus_write(R_CTRL, 32'h3, 4'hF);
    #1 chk("no_rdce_data", rdata, 32'd0);
    for (int t = 1; t <= 9; t++) begin
      logic p;
      p = (t % 3 == 0);
      pulse_tick();
      wait_cyc(6);
      chk($sformatf("per_int_t%0d", t), {31'd0, sint}, {31'd0, p});
      rd_chk(R_PEND, {31'd0, p}, $sformatf("per_pend_t%0d", t));
      rd_chk(R_COUNT, (t % 3 == 0) ? 32'd3 : 32'(3 - (t % 3)), $sformatf("per_cnt_t%0d", t));
      if (p) begin
        bus_write(R_PEND, 32'h1, 4'h1);
        wait_cyc(2);
        chk($sformatf("per_intclr_t%0d", t), {31'd0, sint}, 32'd0);
      end
    end

    // ---- ch1 one-shot, period 2
    do_reset();
    bus_write(R_PER0 + 1, 32'd2, 4'hF);
    bus_write(R_CHCTRL, 32'h202, 4'hF);
    bus_write(R_CTRL, 32'h13, 4'hF);
    pulse_tick(); wait_cyc(6);
    rd_chk(R_PEND, 32'h0, "os_pend_t1");
    pulse_tick(); wait_cyc(6);
    rd_chk(R_PEND, 32'h2, "os_pend_t2");
    chk("os_int", {31'd0, sint}, 32'd1);
    rd_chk(R_CHCTRL, 32'h200, "os_chctrl");
    rd_chk(R_COUNT, 32'd0, "os_count");
    bus_write(R_PEND, 32'h2, 4'h1);
    for (int t = 0; t < 3; t++) begin pulse_tick(); wait_cyc(6); end
    rd_chk(R_PEND, 32'h0, "os_no_refire");
    rd_chk(R_COUNT, 32'd0, "os_count_hold");

    // ---- ticks in SCAN1 and SCAN3: one extra scan, overrun per build
    do_reset();
    bus_write(R_PER0, 32'd100, 4'hF);
    bus_write(R_CHCTRL, 32'h011, 4'hF);
    bus_write(R_CTRL, 32'h3, 4'hF);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk); chk("ovr_in_scan1", {29'd0, dbg}, 32'd2); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk); chk("ovr_in_scan3", {29'd0, dbg}, 32'd4); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    wait_cyc(12);
    rd_chk(R_COUNT, 32'd98, "ovr_two_scans");
    rd_chk(R_CTRL, 32'h3 | exp_ovr, "ovr_flag");
    bus_write(R_CTRL, 32'h103, 4'hF);
    rd_chk(R_CTRL, 32'h3, "ovr_cleared");

    // ---- W1C of PEND[0] in the same cycle as a hardware set
    do_reset();
    bus_write(R_PER0, 32'd1, 4'hF);
    bus_write(R_CHCTRL, 32'h111, 4'hF);
    bus_write(R_CTRL, 32'h3, 4'hF);
    pulse_tick(); wait_cyc(6);
    rd_chk(R_PEND, 32'h1, "w1c_pre");
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0; wr_ce = 8'h80 >> R_PEND; wdata = 32'h1; be = 4'h1;
    @(negedge clk); wr_ce = '0; wdata = '0; be = '0;
    wait_cyc(4);
    rd_chk(R_PEND, 32'h1, "w1c_set_wins");
    bus_write(R_PEND, 32'h1, 4'h1);
    rd_chk(R_PEND, 32'h0, "w1c_plain");

    // ---- reset asserted during SCAN2
    do_reset();
    bus_write(R_PER0, 32'd1, 4'hF);
    bus_write(R_CHCTRL, 32'h111, 4'hF);
    bus_write(R_CTRL, 32'h3, 4'hF);
    pulse_tick(); wait_cyc(6);
    chk("rs_int_pre", {31'd0, sint}, 32'd1);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    @(negedge clk); chk("rs_in_scan2", {29'd0, dbg}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rs_int_now", {31'd0, sint}, 32'd0);
    chk("rs_state_now", {29'd0, dbg}, 32'd0);
    for (int k = 0; k < 8; k++) rd_chk(k, 32'd0, $sformatf("rs_reg%0d", k));
    @(negedge clk); rst_n = 1'b1;
    wait_cyc(3);
    rd_chk(R_PEND, 32'h0, "rs_pend_after");
    chk("rs_int_after", {31'd0, sint}, 32'd0);

    // ---- PERIOD2 write in the same cycle as ch2's firing scan
    do_reset();
    bus_write(R_PER0 + 2, 32'd1, 4'hF);
    bus_write(R_CHCTRL, 32'h404, 4'hF);
    bus_write(R_CTRL, 32'h23, 4'hF);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    @(negedge clk); wr_ce = 8'h80 >> (R_PER0 + 2); wdata = 32'd5; be = 4'hF;
    @(negedge clk); wr_ce = '0; wdata = '0; be = '0;
    wait_cyc(4);
    rd_chk(R_COUNT, 32'd5, "pw_count");
    rd_chk(R_PEND, 32'h0, "pw_pend");
    rd_chk(R_CHCTRL, 32'h404, "pw_chctrl");

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_sched.md
TIMER_SCHED -- requirements
Module: timer_sched

Interface
REQ-001 SHALL have parameter C_NUM_REG, default 8, meaning the number of slave registers and the width of the CE buses.
REQ-002 SHALL have parameter C_SLV_DWIDTH, default 32, meaning the slave data width.
REQ-003 SHALL have port Bus2IP_Clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port Bus2IP_Resetn, input, width 1: reset, asynchronous and active-low.
REQ-005 SHALL have port Tick_Us, input, width 1: one-cycle 1 us tick pulse from the timebase.
REQ-006 SHALL have ports Bus2IP_Data (input, C_SLV_DWIDTH), Bus2IP_BE (input, C_SLV_DWIDTH/8), Bus2IP_RdCE and Bus2IP_WrCE (input, C_NUM_REG each), carrying slave write data, byte enables and one-hot chip enables.
REQ-007 SHALL have ports IP2Bus_Data (output, C_SLV_DWIDTH), IP2Bus_RdAck, IP2Bus_WrAck and IP2Bus_Error (output, 1 each).
REQ-008 SHALL have port Sched_Int, output, width 1: level interrupt.

Function
REQ-009 SHALL select register k by CE bit (C_NUM_REG-1-k); reg0 CTRL, reg1 PEND, reg2-5 PERIOD0-3, reg6 CHCTRL, reg7 COUNT.
REQ-010 SHALL honour byte enables on writes; RdAck/WrAck = OR of the respective CE bits, same cycle; Error = 0; IP2Bus_Data = 0 when no RdCE is active.
REQ-011 SHALL decode CTRL as: bit0 global enable, bit1 global interrupt enable, bits[5:4] COUNT channel select, bit8 overrun (read-only, sticky).
REQ-012 SHALL decode CHCTRL bits[3:0] as channel enable, [7:4] periodic mode and [11:8] interrupt mask, for channels 0-3.
REQ-013 SHALL keep a 32-bit period and a 32-bit remaining count per channel, and SHALL provide one shared decrement/compare datapath.
REQ-014 SHALL implement FSM IDLE -> SCAN0 -> SCAN1 -> SCAN2 -> SCAN3 -> IDLE, one channel per cycle, so a scan takes 4 cycles.
REQ-015 SHALL leave IDLE for SCAN0 only when the global enable is set and either Tick_Us or tick_pend is set; entering SCAN0 clears tick_pend.
REQ-016 SHALL set tick_pend when Tick_Us arrives outside IDLE; if tick_pend is already set, the tick is dropped (see REQ-027).
REQ-017 SHALL treat a scanned channel as follows: if enabled with count=1, set PEND[ch], then reload count=period (periodic) or set count=0 and clear its enable (one-shot); if enabled with count>1, decrement; if disabled or count=0, hold.
REQ-018 SHALL, on a write to PERIODn, load both the period and the count with the written value; a period of 0 never fires.
REQ-019 SHALL reload count=period when a channel's enable goes 0->1 via a CHCTRL write.
REQ-020 SHALL make a bus write to PERIODn/CHCTRL win over a same-cycle scan update of that channel.
REQ-021 SHALL make PEND write-1-to-clear, with a hardware set winning over a same-cycle clear.
REQ-022 SHALL drive Sched_Int = CTRL.bit1 AND OR(PEND[3:0] AND mask[3:0]), registered.
REQ-023 SHALL make a COUNT read return the live count of the channel selected by CTRL[5:4].
REQ-024 SHALL, when the global enable is cleared mid-scan, finish the current scan, return to IDLE and clear tick_pend; counts are held.

Reset
REQ-025 SHALL, while Bus2IP_Resetn=0, asynchronously clear all registers, counts, periods, tick_pend and overrun, put the FSM in IDLE, and drive Sched_Int=0 and IP2Bus_Data=0.
REQ-026 SHALL reset mid-scan to IDLE with no PEND bit set.

Configuration
REQ-027 SHALL, with TIMER_SCHED_OVERRUN_EN defined, set CTRL.bit8 on a dropped tick, clearable by writing 1 to bit8; without it, bit8 reads 0 and drops are silent.

Verification
REQ-028 SHALL cover: PERIOD0=3, ch0 enabled periodic, int enabled -> PEND[0] and Sched_Int set on ticks 3, 6, 9.
REQ-029 SHALL cover: ch1 one-shot with PERIOD1=2 -> PEND[1] set after tick 2, CHCTRL bit1 reads 0, count reads 0, no further set.
REQ-030 SHALL cover: Tick_Us in SCAN1 followed by a second tick in SCAN3 -> exactly one extra scan; with the macro CTRL.bit8=1, without it 0.
REQ-031 SHALL cover: W1C of PEND[0] in the same cycle as a hardware set -> PEND[0] stays 1.
REQ-032 SHALL cover: Bus2IP_Resetn pulsed low during SCAN2 -> all registers read 0 and Sched_Int=0 immediately.
REQ-033 SHALL cover: write PERIOD2=5 while ch2 has count=1 in the same cycle as its scan -> count reads 5 and PEND[2] is not set.
